// File: rtl/requant_pack_int8_pkg.sv
// rtl/requant_pack_int8_pkg.sv - shared constants and word-entry type for the int8 requant packer
package requant_pack_int8_pkg;

    localparam int LANES_DEFAULT = 4;

    // Widest word the entry struct can carry; narrower builds leave upper fields at zero.
    localparam int MAX_LANES = 8;

    localparam logic [7:0] INT8_MIN = 8'h80;
    localparam logic [7:0] INT8_MAX = 8'h7F;

    typedef struct packed {
        logic [8*MAX_LANES-1:0] data;
        logic [MAX_LANES-1:0]   mask;
        logic                   last;
    } word_entry_t;

endpackage

// File: rtl/requant_pack_int8_word_fifo.sv
// rtl/requant_pack_int8_word_fifo.sv - synchronous FIFO holding completed output words
module word_fifo
    import requant_pack_int8_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  word_entry_t push_entry,
    output logic        full,
    input  logic        pop,
    output logic        valid,
    output word_entry_t head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    word_entry_t   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign valid   = (count != '0);
    assign do_push = push && !full;
    assign do_pop  = pop && valid;

    // Head reads as zero while empty so outputs are clean after reset without clearing storage.
    assign head = valid ? mem[rd_ptr] : '0;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Pointer and occupancy bookkeeping; push and pop in one cycle leave count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/requant_pack_int8.sv
// rtl/requant_pack_int8.sv - zero-point add, activation clamp and int8 lane packing
module requant_pack_int8
    import requant_pack_int8_pkg::*;
#(
    parameter int LANES      = LANES_DEFAULT,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [31:0]          in_data,
    input  logic                 in_last,
    output logic                 in_ready,
    input  logic [31:0]          output_zero_point,
    input  logic [7:0]           act_min,
    input  logic [7:0]           act_max,
    output logic                 out_valid,
    output logic [8*LANES-1:0]   out_data,
    output logic [LANES-1:0]     out_mask,
    output logic                 out_last,
    input  logic                 out_ready,
    input  logic                 clr_stats,
    output logic [15:0]          sat_count
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    logic               accept;
    logic               fifo_full;
    logic signed [32:0] sum;
    logic signed [32:0] lo;
    logic signed [32:0] hi;
    logic signed [32:0] floor_v;
    logic signed [32:0] clamped;
    logic               sat;
    logic [LW-1:0]      lane;
    logic [8*LANES-1:0] acc_data;
    logic [8*LANES-1:0] word_data;
    logic [LANES-1:0]   acc_mask;
    logic [LANES-1:0]   word_mask;
    logic               word_done;
    word_entry_t        push_entry;
    word_entry_t        head;

    assign in_ready = !fifo_full;
    assign accept   = in_valid && in_ready;

    // 33 bits so the zero-point add can never wrap.
    assign sum = $signed({in_data[31], in_data}) + $signed({output_zero_point[31], output_zero_point});
    assign lo  = $signed({{25{act_min[7]}}, act_min});
    assign hi  = $signed({{25{act_max[7]}}, act_max});

    // Clamp as min(max(sum, lo), hi) so the upper bound wins when the range is inverted.
    always_comb begin
        floor_v = (sum < lo) ? lo : sum;
        clamped = (floor_v > hi) ? hi : floor_v;
        sat     = (sum < lo) || (sum > hi);
    end

    // The clamped value always fits in int8, so only its low byte is carried forward.
    logic unused_clamp_hi;
    assign unused_clamp_hi = ^clamped[32:8];

    // Merge the current element into the partial word and build the FIFO entry.
    always_comb begin
        word_data = acc_data;
        word_mask = acc_mask;
        for (int k = 0; k < LANES; k++) begin
            if (lane == LW'(k)) begin
                word_data[8*k +: 8] = clamped[7:0];
                word_mask[k]        = 1'b1;
            end
        end
        word_done                     = accept && (in_last || lane == LW'(LANES - 1));
        push_entry                    = '0;
        push_entry.data[8*LANES-1:0]  = word_data;
        push_entry.mask[LANES-1:0]    = word_mask;
        push_entry.last               = in_last;
    end

    // Lane counter and partial-word accumulator; a finished word restarts at lane 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            lane     <= '0;
            acc_data <= '0;
            acc_mask <= '0;
        end else if (accept) begin
            if (word_done) begin
                lane     <= '0;
                acc_data <= '0;
                acc_mask <= '0;
            end else begin
                lane     <= lane + 1'b1;
                acc_data <= word_data;
                acc_mask <= word_mask;
            end
        end
    end

    // Saturation statistics; a clear beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            sat_count <= '0;
        end else if (accept && sat && sat_count != 16'hFFFF) begin
            sat_count <= sat_count + 16'd1;
        end
    end

    word_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_word_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (word_done),
        .push_entry (push_entry),
        .full       (fifo_full),
        .pop        (out_ready),
        .valid      (out_valid),
        .head       (head)
    );

    assign out_data = head.data[8*LANES-1:0];
    assign out_mask = head.mask[LANES-1:0];
    assign out_last = head.last;

    if (LANES < MAX_LANES) begin : g_narrow
        logic unused_entry_hi;
        assign unused_entry_hi = ^{head.data[8*MAX_LANES-1:8*LANES], head.mask[MAX_LANES-1:LANES]};
    end

endmodule
